// File: rtl/readout_scheduler.sv
// -----------------------------------------------------------------------------
// readout_scheduler
//
// Drives one shared frequency_module across a bank of pixel channels. Each
// enabled channel is visited in ascending order: its pixel value is loaded,
// the converter is held in reset for one cycle and allowed to settle, and then
// a fixed number of FREQ_IN rising edges is counted. The period from the first
// to the last counted edge is reported per channel.
//
// Ports
//   CLK, RST       single clock, synchronous active-high reset
//   ENABLE         run request; dropping it aborts to IDLE
//   CONTINUOUS     1 = restart frames back to back, 0 = single frame
//   CHANNEL_MASK   channels to scan, latched at each frame start
//   PIXEL_VALUES   packed pixel values, channel i at [i*INPUT_BITS +: INPUT_BITS]
//   FREQ_IN        converter output, asynchronous to CLK
//   INPUT_VALUE    pixel value presented to the converter
//   MOD_RST_N      converter reset (active low)
//   CHANNEL        current / last-completed channel index
//   MEAS_CYCLES    cycles between first and last counted edge (0 on timeout)
//   EDGE_COUNT     edges seen on the last channel
//   CHANNEL_DONE   1-cycle pulse when a channel result is valid
//   TIMEOUT        1-cycle pulse with CHANNEL_DONE when the channel timed out
//   FRAME_DONE     1-cycle pulse when the last enabled channel completes
//   BUSY           high in every state except IDLE
// -----------------------------------------------------------------------------
module readout_scheduler #(
  parameter int NUM_CHANNELS      = 4,
  parameter int INPUT_BITS        = 8,
  parameter int SETTLE_CYCLES     = 100,
  parameter int EDGES_PER_CHANNEL = 5,
  parameter int CYCLE_BITS        = 16,
  localparam int CH_BITS = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int EC_BITS = $clog2(EDGES_PER_CHANNEL + 1)
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               ENABLE,
  input  logic                               CONTINUOUS,
  input  logic [NUM_CHANNELS-1:0]            CHANNEL_MASK,
  input  logic [NUM_CHANNELS*INPUT_BITS-1:0] PIXEL_VALUES,
  input  logic                               FREQ_IN,
  output logic [INPUT_BITS-1:0]              INPUT_VALUE,
  output logic                               MOD_RST_N,
  output logic [CH_BITS-1:0]                 CHANNEL,
  output logic [CYCLE_BITS-1:0]              MEAS_CYCLES,
  output logic [EC_BITS-1:0]                 EDGE_COUNT,
  output logic                               CHANNEL_DONE,
  output logic                               TIMEOUT,
  output logic                               FRAME_DONE,
  output logic                               BUSY
);

  localparam int ST_BITS = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [ST_BITS-1:0]    SETTLE_LAST = ST_BITS'(SETTLE_CYCLES - 1);
  localparam logic [EC_BITS-1:0]    EDGE_LAST   = EC_BITS'(EDGES_PER_CHANNEL - 1);
  localparam logic [EC_BITS-1:0]    EDGE_TOTAL  = EC_BITS'(EDGES_PER_CHANNEL);
  // Last COUNT cycle: the counter would reach 2^CYCLE_BITS-1 on this clock.
  localparam logic [CYCLE_BITS-1:0] CYCLE_LAST  = {{(CYCLE_BITS-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_COUNT, S_NEXT
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              sync_q, sync_d;
  logic                    prev_q, prev_d;
  logic                    edge_q, edge_d;
  logic [NUM_CHANNELS-1:0] frame_mask_q, frame_mask_d;
  logic [CH_BITS-1:0]      sel_q, sel_d;
  logic [CH_BITS-1:0]      channel_q, channel_d;
  logic [INPUT_BITS-1:0]   input_value_q, input_value_d;
  logic [ST_BITS-1:0]      settle_cnt_q, settle_cnt_d;
  logic [CYCLE_BITS-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [CYCLE_BITS-1:0]   period_cnt_q, period_cnt_d;
  logic [EC_BITS-1:0]      edge_cnt_q, edge_cnt_d;
  logic [CYCLE_BITS-1:0]   meas_q, meas_d;
  logic [EC_BITS-1:0]      edge_count_q, edge_count_d;
  logic                    timeout_flag_q, timeout_flag_d;

  logic [CH_BITS-1:0]      mask_low_idx;
  logic                    next_found;
  logic [CH_BITS-1:0]      next_idx;
  logic                    final_edge;
  logic                    cycle_expire;
  logic                    mask_any;

  // Channel selection helpers: lowest set bit of the live mask (frame start)
  // and next set bit above the current channel in the latched frame mask.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    mask_low_idx = '0;
    next_found   = 1'b0;
    next_idx     = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (CHANNEL_MASK[i]) mask_low_idx = CH_BITS'(i);
      if (frame_mask_q[i] && (i > int'(channel_q))) begin
        next_found = 1'b1;
        next_idx   = CH_BITS'(i);
      end
    end
  end

  assign mask_any     = |CHANNEL_MASK;
  assign final_edge   = edge_q && (edge_cnt_q == EDGE_LAST);
  assign cycle_expire = (cycle_cnt_q == CYCLE_LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their inputs from the same pre-edge values.
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (ENABLE && mask_any) state_d = S_LOAD;
      S_LOAD:   state_d = ENABLE ? S_SETTLE : S_IDLE;
      S_SETTLE: begin
        if (!ENABLE)                          state_d = S_IDLE;
        else if (settle_cnt_q == SETTLE_LAST) state_d = S_COUNT;
      end
      S_COUNT: begin
        if (!ENABLE)                          state_d = S_IDLE;
        else if (final_edge || cycle_expire)  state_d = S_NEXT;
      end
      S_NEXT: begin
        if (!ENABLE)                          state_d = S_IDLE;
        else if (next_found)                  state_d = S_LOAD;
        else if (CONTINUOUS && mask_any)      state_d = S_LOAD;
        else                                  state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Pulses are suppressed in an abort cycle (ENABLE low) and
  // while RST is asserted.
  // ---------------------------------------------------------------------------
  always_comb begin
    BUSY         = !RST && (state_q != S_IDLE);
    MOD_RST_N    = !RST && ((state_q == S_SETTLE) || (state_q == S_COUNT));
    CHANNEL_DONE = !RST && ENABLE && (state_q == S_NEXT);
    TIMEOUT      = CHANNEL_DONE && timeout_flag_q;
    FRAME_DONE   = CHANNEL_DONE && !next_found;
  end

  assign INPUT_VALUE = input_value_q;
  assign CHANNEL     = channel_q;
  assign MEAS_CYCLES = meas_q;
  assign EDGE_COUNT  = edge_count_q;

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    // FREQ_IN: two synchronizer stages, then a registered rising-edge detect.
    sync_d         = {sync_q[0], FREQ_IN};
    prev_d         = sync_q[1];
    edge_d         = sync_q[1] && !prev_q;
    frame_mask_d   = frame_mask_q;
    sel_d          = sel_q;
    channel_d      = channel_q;
    input_value_d  = input_value_q;
    settle_cnt_d   = settle_cnt_q;
    cycle_cnt_d    = cycle_cnt_q;
    period_cnt_d   = period_cnt_q;
    edge_cnt_d     = edge_cnt_q;
    meas_d         = meas_q;
    edge_count_d   = edge_count_q;
    timeout_flag_d = timeout_flag_q;

    case (state_q)
      S_IDLE: begin
        if (ENABLE && mask_any) begin
          frame_mask_d = CHANNEL_MASK;
          sel_d        = mask_low_idx;
        end
      end
      S_LOAD: begin
        if (ENABLE) begin
          channel_d     = sel_q;
          input_value_d = PIXEL_VALUES[int'(sel_q)*INPUT_BITS +: INPUT_BITS];
          settle_cnt_d  = '0;
        end
      end
      S_SETTLE: begin
        // Measurement counters are held clear so COUNT starts from zero.
        settle_cnt_d   = settle_cnt_q + ST_BITS'(1);
        cycle_cnt_d    = '0;
        period_cnt_d   = '0;
        edge_cnt_d     = '0;
        timeout_flag_d = 1'b0;
      end
      S_COUNT: begin
        if (ENABLE) begin
          cycle_cnt_d = cycle_cnt_q + CYCLE_BITS'(1);
          // Period restarts at the first edge; before it the value is unused.
          if (edge_q && (edge_cnt_q == '0)) period_cnt_d = '0;
          else                              period_cnt_d = period_cnt_q + CYCLE_BITS'(1);
          if (edge_q) edge_cnt_d = edge_cnt_q + EC_BITS'(1);
          // The final edge wins over a coincident timeout.
          if (final_edge) begin
            meas_d       = period_cnt_q + CYCLE_BITS'(1);
            edge_count_d = EDGE_TOTAL;
          end else if (cycle_expire) begin
            meas_d         = '0;
            edge_count_d   = edge_cnt_q + EC_BITS'(edge_q);
            timeout_flag_d = 1'b1;
          end
        end
      end
      S_NEXT: begin
        if (ENABLE) begin
          if (next_found) begin
            sel_d = next_idx;
          end else if (CONTINUOUS && mask_any) begin
            frame_mask_d = CHANNEL_MASK;
            sel_d        = mask_low_idx;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q         <= '0;
      prev_q         <= 1'b0;
      edge_q         <= 1'b0;
      frame_mask_q   <= '0;
      sel_q          <= '0;
      channel_q      <= '0;
      input_value_q  <= '0;
      settle_cnt_q   <= '0;
      cycle_cnt_q    <= '0;
      period_cnt_q   <= '0;
      edge_cnt_q     <= '0;
      meas_q         <= '0;
      edge_count_q   <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      prev_q         <= prev_d;
      edge_q         <= edge_d;
      frame_mask_q   <= frame_mask_d;
      sel_q          <= sel_d;
      channel_q      <= channel_d;
      input_value_q  <= input_value_d;
      settle_cnt_q   <= settle_cnt_d;
      cycle_cnt_q    <= cycle_cnt_d;
      period_cnt_q   <= period_cnt_d;
      edge_cnt_q     <= edge_cnt_d;
      meas_q         <= meas_d;
      edge_count_q   <= edge_count_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

endmodule

// File: tb/tb_readout_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for readout_scheduler. FREQ_IN comes from a square-wave stub of
// period P cycles. Expected per-channel results come from a frame model:
// channels are the set mask bits in ascending order and a clean square wave
// of period P gives (EDGES_PER_CHANNEL-1)*P measured cycles.
// -----------------------------------------------------------------------------
module tb_readout_scheduler;

  localparam int NCH = 4;
  localparam int IB  = 8;
  localparam int ST  = 10;
  localparam int EPC = 4;
  localparam int CB  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              continuous;
  logic [NCH-1:0]    mask;
  logic [NCH*IB-1:0] pix;
  logic              freq_in;
  logic [IB-1:0]     input_value;
  logic              mod_rst_n;
  logic [1:0]        channel;
  logic [CB-1:0]     meas;
  logic [2:0]        edge_count;
  logic              channel_done;
  logic              timeout;
  logic              frame_done;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  // Square-wave stub controls: period 0 holds FREQ_IN low; edges_left < 0 is
  // unlimited, otherwise the wave stops low after that many rising edges.
  int gen_period     = 0;
  int gen_edges_left = -1;
  int gen_phase      = 0;

  // Model of the last reported result, used to check retention on abort.
  int last_meas = 0;
  int last_edges = 0;

  readout_scheduler #(
    .NUM_CHANNELS(NCH), .INPUT_BITS(IB), .SETTLE_CYCLES(ST),
    .EDGES_PER_CHANNEL(EPC), .CYCLE_BITS(CB)
  ) dut (
    .CLK(clk), .RST(rst), .ENABLE(enable), .CONTINUOUS(continuous),
    .CHANNEL_MASK(mask), .PIXEL_VALUES(pix), .FREQ_IN(freq_in),
    .INPUT_VALUE(input_value), .MOD_RST_N(mod_rst_n), .CHANNEL(channel),
    .MEAS_CYCLES(meas), .EDGE_COUNT(edge_count), .CHANNEL_DONE(channel_done),
    .TIMEOUT(timeout), .FRAME_DONE(frame_done), .BUSY(busy)
  );

  always #5 clk = ~clk;

  initial begin
    freq_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (gen_period == 0 || gen_edges_left == 0) begin
        freq_in = 1'b0;
      end else begin
        gen_phase = gen_phase % gen_period;
        if (gen_phase == 0) begin
          freq_in = 1'b1;
          if (gen_edges_left > 0) gen_edges_left--;
        end else if (gen_phase == gen_period / 2) begin
          freq_in = 1'b0;
        end
        gen_phase = (gen_phase + 1) % gen_period;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [25:0] all_outputs();
    return {input_value, mod_rst_n, channel, meas, edge_count,
            channel_done, timeout, frame_done, busy};
  endfunction

  // Runs one single-shot frame and checks every CHANNEL_DONE against the model.
  task automatic run_frame(input logic [NCH-1:0] m, input logic [NCH*IB-1:0] p,
                           input int period, input int exp_meas, input int exp_n);
    int q[$];
    int ch;
    int n_done = 0;
    bit finished = 0;
    for (int i = 0; i < NCH; i++) if (m[i]) q.push_back(i);
    @(posedge clk); #1;
    mask = m; pix = p; continuous = 1'b0;
    gen_period = period; gen_edges_left = -1; gen_phase = 0;
    enable = 1'b1;
    for (int c = 0; c < 3000 && !finished; c++) begin
      @(negedge clk);
      if (channel_done) begin
        n_done++;
        if (q.size() == 0) begin
          check("extra_channel_done", 1, 0);
          finished = 1;
        end else begin
          ch = q.pop_front();
          check("frame_channel", channel, ch);
          check("frame_input_value", input_value, p[ch*IB +: IB]);
          check("frame_meas", meas, exp_meas);
          check("frame_edge_count", edge_count, EPC);
          check("frame_timeout_flag", timeout, 0);
          check("frame_done_flag", frame_done, q.size() == 0);
          last_meas = exp_meas; last_edges = EPC;
          if (frame_done) finished = 1;
        end
      end
    end
    if (!finished) check("frame_budget", 0, 1);
    check("frame_done_count", n_done, exp_n);
    @(posedge clk); #1;
    enable = 1'b0;
    @(negedge clk);
    check("frame_idle_busy", busy, 0);
    check("frame_idle_mod_rst_n", mod_rst_n, 0);
  endtask

  typedef struct {
    logic [NCH-1:0]    m;
    logic [NCH*IB-1:0] p;
    int                period;
    int                exp_meas;
    int                exp_n;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n, done_at, f_prev, f_cur, exp_gap, n_frames;
    bit seen;
    logic [NCH-1:0] rm;

    vecs[0] = '{4'b1111, 32'h40302010, 20, 60, 4};
    vecs[1] = '{4'b1010, 32'h9a8b7c6d,  8, 24, 2};
    vecs[2] = '{4'b0001, 32'h000000c3,  6, 18, 1};
    vecs[3] = '{4'b1000, 32'h5e000000, 30, 90, 1};

    rst = 1'b1; enable = 1'b0; continuous = 1'b0; mask = '0; pix = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", all_outputs(), 0);

    // ENABLE with an empty mask never leaves IDLE.
    @(posedge clk); #1;
    enable = 1'b1; mask = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("empty_mask_busy", busy, 0);
    end
    @(posedge clk); #1 enable = 1'b0;

    for (int v = 0; v < 4; v++)
      run_frame(vecs[v].m, vecs[v].p, vecs[v].period, vecs[v].exp_meas, vecs[v].exp_n);

    for (int r = 0; r < 6; r++) begin
      int per;
      int cnt;
      rm  = NCH'($urandom_range(1, 15));
      per = $urandom_range(4, 60);
      cnt = 0;
      for (int i = 0; i < NCH; i++) cnt += rm[i];
      run_frame(rm, $urandom, per, (EPC - 1) * per, cnt);
    end

    // Timeout with FREQ_IN held low: LOAD at +1, SETTLE for ST cycles,
    // 2^CB-1 COUNT cycles, then NEXT.
    @(posedge clk); #1;
    gen_period = 0; mask = 4'b0001; enable = 1'b1;
    done_at = -1;
    for (int c = 0; c < 400 && done_at < 0; c++) begin
      @(negedge clk);
      if (channel_done) done_at = c;
    end
    check("timeout_done_cycle", done_at, 1 + ST + ((1 << CB) - 1) + 1);
    check("timeout_flag", timeout, 1);
    check("timeout_edges", edge_count, 0);
    check("timeout_meas", meas, 0);
    check("timeout_frame_done", frame_done, 1);
    @(posedge clk); #1 enable = 1'b0;
    repeat (2) @(posedge clk);

    // Two edges then stuck low.
    #1 enable = 1'b1;
    repeat (15) @(negedge clk);
    @(posedge clk); #1;
    gen_phase = 0; gen_edges_left = 2; gen_period = 10;
    seen = 0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (channel_done) seen = 1;
    end
    check("stuck_seen", seen, 1);
    check("stuck_timeout", timeout, 1);
    check("stuck_edges", edge_count, 2);
    check("stuck_meas", meas, 0);
    @(posedge clk); #1;
    enable = 1'b0; gen_edges_left = -1;

    // Continuous mode: after a final edge the next counted edge is the first
    // wave edge past NEXT+LOAD+SETTLE, then EPC-1 more periods.
    @(posedge clk); #1;
    mask = 4'b0001; pix = 32'h11223344; continuous = 1'b1;
    gen_period = 10; gen_phase = 0; enable = 1'b1;
    exp_gap = 10 * ((ST + 3 + 9) / 10) + (EPC - 1) * 10;
    f_prev = -1; n_frames = 0;
    for (int c = 0; c < 1000 && n_frames < 3; c++) begin
      @(negedge clk);
      if (frame_done) begin
        f_cur = c;
        check("cont_channel", channel, 0);
        check("cont_meas", meas, 30);
        if (f_prev >= 0) check("cont_frame_gap", f_cur - f_prev, exp_gap);
        f_prev = f_cur;
        n_frames++;
      end
    end
    check("cont_frames", n_frames, 3);
    @(posedge clk); #1 mask = 4'b0100;
    seen = 0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (channel_done) seen = 1;
    end
    check("cont_old_mask_channel", channel, 0);
    check("cont_old_mask_frame_done", frame_done, 1);
    @(posedge clk); #1 continuous = 1'b0;
    seen = 0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (channel_done) seen = 1;
    end
    check("cont_new_mask_channel", channel, 2);
    check("cont_new_mask_input", input_value, 8'h22);
    check("cont_new_mask_frame_done", frame_done, 1);
    last_meas = 30; last_edges = EPC;
    @(negedge clk);
    check("cont_stop_busy", busy, 0);
    @(posedge clk); #1 enable = 1'b0;

    // Frame start timing, then abort mid-COUNT.
    @(posedge clk); #1;
    mask = 4'b0010; pix = 32'h00005a00; enable = 1'b1;
    @(negedge clk);
    check("start_idle_busy", busy, 0);
    @(negedge clk);
    check("start_load_busy", busy, 1);
    check("start_load_mod_rst_n", mod_rst_n, 0);
    @(negedge clk);
    check("start_settle_mod_rst_n", mod_rst_n, 1);
    check("start_input_value", input_value, 8'h5a);
    check("start_channel", channel, 1);
    n = 0;
    for (int c = 3; c <= 20; c++) begin
      @(negedge clk);
      if (channel_done) n++;
    end
    @(posedge clk); #1 enable = 1'b0;
    @(negedge clk);
    check("abort_cycle_pulses", {channel_done, timeout, frame_done} | 3'(n), 0);
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_mod_rst_n", mod_rst_n, 0);
    check("abort_meas_kept", meas, last_meas);
    check("abort_edges_kept", edge_count, last_edges);

    // Reset mid-SETTLE.
    @(posedge clk); #1;
    mask = 4'b1111; pix = 32'h11223344; enable = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    @(posedge clk); #1;
    rst = 1'b1; enable = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("reset_mid_settle_outputs", all_outputs(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/readout_scheduler.md
# readout_scheduler

Sequences the `frequency_module` light-to-frequency converter across a bank of pixel channels.
- Selects each enabled channel in ascending order and loads its value into `INPUT_VALUE`.
- Holds the converter in reset for one cycle, then lets it settle.
- Counts a fixed number of `FREQ_OUT` rising edges and reports the measured period.
- Sits between the pixel front end and the single shared `frequency_module` instance; the result feeds the readout/serializer logic.

## Interface
- `NUM_CHANNELS`, 4: number of pixel channels; minimum 1.
- `INPUT_BITS`, 8: width of each pixel value; matches `frequency_module.INPUT_BITS`.
- `SETTLE_CYCLES`, 100: cycles spent in SETTLE after the module reset; minimum 1.
- `EDGES_PER_CHANNEL`, 5: rising edges counted per channel; minimum 2.
- `CYCLE_BITS`, 16: width of the cycle counter; the COUNT timeout is 2^CYCLE_BITS−1 cycles.
- `CLK`, input, 1: the single clock.
- `RST`, input, 1: synchronous, active-high reset.
- `ENABLE`, input, 1: run request; deassertion aborts.
- `CONTINUOUS`, input, 1: 1 = restart frames back to back; 0 = run a single frame.
- `CHANNEL_MASK`, input, NUM_CHANNELS: bit i set = channel i is scanned.
- `PIXEL_VALUES`, input, NUM_CHANNELS*INPUT_BITS: channel i occupies bits [i*INPUT_BITS +: INPUT_BITS].
- `FREQ_IN`, input, 1: from `frequency_module.FREQ_OUT`; treated as asynchronous.
- `INPUT_VALUE`, output, INPUT_BITS: to `frequency_module.INPUT_VALUE`.
- `MOD_RST_N`, output, 1: to `frequency_module.RST_N`.
- `CHANNEL`, output, max(1,$clog2(NUM_CHANNELS)): index of the current or last-completed channel.
- `MEAS_CYCLES`, output, CYCLE_BITS: cycles from the first counted edge to the last counted edge.
- `EDGE_COUNT`, output, $clog2(EDGES_PER_CHANNEL+1): edges seen on the last channel.
- `CHANNEL_DONE`, output, 1: 1-cycle pulse when a channel's result is valid.
- `TIMEOUT`, output, 1: 1-cycle pulse alongside `CHANNEL_DONE` when the measurement timed out.
- `FRAME_DONE`, output, 1: 1-cycle pulse on completion of the last enabled channel.
- `BUSY`, output, 1: high in every state except IDLE.

## Operation
- **FREQ_IN conditioning**
  - `FREQ_IN` passes through a 2-flop synchronizer.
  - A rising edge is detected on the synchronized signal (synchronized bit 1, previous bit 0).
- **States: IDLE, LOAD, SETTLE, COUNT, NEXT.**
- **IDLE**
  - If `ENABLE`=1 and `CHANNEL_MASK`≠0: latch the mask into a frame mask, select the lowest set bit, go to LOAD.
  - If the mask is 0: stay in IDLE.
  - `MOD_RST_N`=0.
- **LOAD (1 cycle)**
  - Latch the selected slice of `PIXEL_VALUES` into `INPUT_VALUE`; update `CHANNEL`.
  - `MOD_RST_N`=0.
  - Go to SETTLE.
- **SETTLE (exactly SETTLE_CYCLES cycles)**
  - `MOD_RST_N`=1; edges are ignored.
  - Go to COUNT.
- **COUNT**
  - The cycle counter starts at 0 on entry and increments every cycle.
  - The edge counter increments on each detected edge.
  - The period counter clears on the first edge and increments each cycle thereafter.
  - On the EDGES_PER_CHANNEL-th edge: latch `MEAS_CYCLES`, `EDGE_COUNT`; go to NEXT.
  - If the cycle counter reaches 2^CYCLE_BITS−1 first: latch `MEAS_CYCLES`=0 and `EDGE_COUNT`=edges so far, set the timeout flag, go to NEXT.
  - If the final edge and the timeout occur in the same cycle, the edge wins and no timeout is flagged.
- **NEXT (1 cycle)**
  - Pulse `CHANNEL_DONE`; pulse `TIMEOUT` if flagged.
  - Find the next higher set bit in the frame mask.
    - Found: go to LOAD.
    - Not found: pulse `FRAME_DONE`; if `CONTINUOUS`=1 and `ENABLE`=1, re-latch the mask (if nonzero) and go to LOAD of its lowest channel; otherwise go to IDLE.
- **Mask changes**
  - Changes to `CHANNEL_MASK` mid-frame have no effect until the next frame latch.
  - `PIXEL_VALUES` is sampled only in LOAD.
- **ENABLE abort**
  - `ENABLE`=0 in LOAD, SETTLE, COUNT or NEXT forces IDLE on the next cycle.
  - No `CHANNEL_DONE`, `TIMEOUT` or `FRAME_DONE` pulse is produced in the abort cycle.
  - Already-latched results are retained.
- **Reset**
  - All outputs are 0 (`MOD_RST_N`=0, `BUSY`=0); state is IDLE; all counters are 0.
  - `RST` overrides everything in the same cycle, including mid-COUNT.

## Timing
- `ENABLE` rises in cycle t → LOAD in t+1 → SETTLE from t+2 to t+1+SETTLE_CYCLES → COUNT from t+2+SETTLE_CYCLES.
- Edge-detect latency from a `FREQ_IN` transition is 3 cycles: 2 synchronizer stages plus the detect register.
- `CHANNEL_DONE` asserts the cycle after the final edge is detected.
- Results on `MEAS_CYCLES` and `EDGE_COUNT` are valid in the `CHANNEL_DONE` cycle and held until the next `CHANNEL_DONE` or reset.
- `INPUT_VALUE` is stable from LOAD+1 until the next LOAD.
- Per-channel overhead beyond the measurement is 1 (LOAD) + SETTLE_CYCLES + 1 (NEXT) cycles.
- `BUSY` is high from the LOAD cycle through the final NEXT cycle.

## Test plan
Common bench parameters: NUM_CHANNELS=4, SETTLE_CYCLES=10, EDGES_PER_CHANNEL=4, CYCLE_BITS=8; `FREQ_IN` is driven by a stub with a square wave of period P cycles.

- **Single frame.** Mask=4'b1111, CONTINUOUS=0, values {8'h40,8'h30,8'h20,8'h10}, P=20 → `INPUT_VALUE` presents 10,20,30,40 in order; `CHANNEL_DONE` ×4 with `MEAS_CYCLES`=60 each; one `FRAME_DONE` coincident with the 4th `CHANNEL_DONE`; then IDLE with `BUSY`=0.
- **Sparse mask.** Mask=4'b1010, P=8 → only channels 1 then 3 are scanned; `MEAS_CYCLES`=24; `FRAME_DONE` on channel 3.
- **Timeout.** `FREQ_IN` held low → `CHANNEL_DONE` and `TIMEOUT` after 255 COUNT cycles; `EDGE_COUNT`=0; `MEAS_CYCLES`=0. Also, exactly 2 edges then stuck → `EDGE_COUNT`=2.
- **Continuous mode.** CONTINUOUS=1, mask=4'b0001 → repeated frames; `FRAME_DONE` every 1+10+1+measurement cycles; after the mask is changed to 4'b0100 mid-frame, the next frame scans channel 2.
- **Abort.** `ENABLE` dropped mid-COUNT → IDLE next cycle; no `CHANNEL_DONE`; `MOD_RST_N`=0; previous results unchanged.
- **Reset.** `RST` asserted mid-SETTLE → all outputs 0 the next cycle. Also, `ENABLE`=1 with mask=0 → stays IDLE with `BUSY`=0.
